// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - BCD hh:mm:ss time-of-day counter with 1 Hz prescaler and MSF load
//
// Free-running 24 h BCD clock. A prescaler divides clk by CLK_HZ to produce
// the one-second advance. The MSF decoder loads hours and minutes at each
// minute marker; an accepted load zeroes the seconds and restarts the
// prescaler so the count stays aligned to the minute boundary.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   load_i                     one-cycle load strobe
//   load_hour_h_i/_l_i         BCD hours to load (00-23)
//   load_min_h_i/_l_i          BCD minutes to load (00-59)
//   hour_h/l_digit_o           BCD hours
//   min_h/l_digit_o            BCD minutes
//   sec_h/l_digit_o            BCD seconds
//   sec_tick_o                 registered pulse on each seconds increment
//   time_valid_o               sticky: a load has been accepted since reset
//   load_err_o                 registered pulse: load rejected

module bcd_time_counter #(
  parameter int CLK_HZ = 32768
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [1:0] load_hour_h_i,
  input  logic [3:0] load_hour_l_i,
  input  logic [2:0] load_min_h_i,
  input  logic [3:0] load_min_l_i,
  output logic [1:0] hour_h_digit_o,
  output logic [3:0] hour_l_digit_o,
  output logic [2:0] min_h_digit_o,
  output logic [3:0] min_l_digit_o,
  output logic [2:0] sec_h_digit_o,
  output logic [3:0] sec_l_digit_o,
  output logic       sec_tick_o,
  output logic       time_valid_o,
  output logic       load_err_o
);

  localparam int            PW         = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    hour_h_q, hour_h_d;
  logic [3:0]    hour_l_q, hour_l_d;
  logic [2:0]    min_h_q, min_h_d;
  logic [3:0]    min_l_q, min_l_d;
  logic [2:0]    sec_h_q, sec_h_d;
  logic [3:0]    sec_l_q, sec_l_d;
  logic          tick_q, tick_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic load_ok;
  logic accept;
  logic reject;
  logic terminal;
  logic advance;

  // Per-digit rollover conditions feeding the carry chain.
  logic sec_l_last;
  logic sec_h_last;
  logic min_l_last;
  logic min_h_last;
  logic hour_l_last;
  logic day_last;

  // Hours tens of 3 is representable on 2 bits but is never a valid hour,
  // and tens = 2 restricts units to 0-3.
  always_comb begin
    load_ok = (load_min_l_i <= 4'd9) &&
              (load_min_h_i <= 3'd5) &&
              (load_hour_l_i <= 4'd9) &&
              ((load_hour_h_i < 2'd2) ||
               ((load_hour_h_i == 2'd2) && (load_hour_l_i <= 4'd3)));
  end

  assign accept   = load_i && load_ok;
  assign reject   = load_i && !load_ok;
  assign terminal = (presc_q == PRESC_LAST);
  // An accepted load owns the cycle; a rejected one leaves the tick alone.
  assign advance  = terminal && !accept;

  assign sec_l_last  = (sec_l_q == 4'd9);
  assign sec_h_last  = (sec_h_q == 3'd5);
  assign min_l_last  = (min_l_q == 4'd9);
  assign min_h_last  = (min_h_q == 3'd5);
  assign hour_l_last = (hour_l_q == 4'd9);
  assign day_last    = (hour_h_q == 2'd2) && (hour_l_q == 4'd3);

  always_comb begin
    presc_d  = presc_q;
    hour_h_d = hour_h_q;
    hour_l_d = hour_l_q;
    min_h_d  = min_h_q;
    min_l_d  = min_l_q;
    sec_h_d  = sec_h_q;
    sec_l_d  = sec_l_q;
    tick_d   = 1'b0;
    valid_d  = valid_q;
    err_d    = reject;

    if (accept) begin
      presc_d  = '0;
      hour_h_d = load_hour_h_i;
      hour_l_d = load_hour_l_i;
      min_h_d  = load_min_h_i;
      min_l_d  = load_min_l_i;
      sec_h_d  = 3'd0;
      sec_l_d  = 4'd0;
      valid_d  = 1'b1;
    end else if (advance) begin
      presc_d = '0;
      tick_d  = 1'b1;

      sec_l_d = sec_l_last ? 4'd0 : sec_l_q + 4'd1;

      if (sec_l_last) begin
        sec_h_d = sec_h_last ? 3'd0 : sec_h_q + 3'd1;
      end

      if (sec_l_last && sec_h_last) begin
        min_l_d = min_l_last ? 4'd0 : min_l_q + 4'd1;
        if (min_l_last) begin
          min_h_d = min_h_last ? 3'd0 : min_h_q + 3'd1;
        end

        // Hour carry: 23 wraps to 00, otherwise units 9 rolls into tens.
        if (min_l_last && min_h_last) begin
          if (day_last) begin
            hour_h_d = 2'd0;
            hour_l_d = 4'd0;
          end else if (hour_l_last) begin
            hour_h_d = hour_h_q + 2'd1;
            hour_l_d = 4'd0;
          end else begin
            hour_l_d = hour_l_q + 4'd1;
          end
        end
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      hour_h_q <= 2'd0;
      hour_l_q <= 4'd0;
      min_h_q  <= 3'd0;
      min_l_q  <= 4'd0;
      sec_h_q  <= 3'd0;
      sec_l_q  <= 4'd0;
      tick_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      hour_h_q <= hour_h_d;
      hour_l_q <= hour_l_d;
      min_h_q  <= min_h_d;
      min_l_q  <= min_l_d;
      sec_h_q  <= sec_h_d;
      sec_l_q  <= sec_l_d;
      tick_q   <= tick_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign hour_h_digit_o = hour_h_q;
  assign hour_l_digit_o = hour_l_q;
  assign min_h_digit_o  = min_h_q;
  assign min_l_digit_o  = min_l_q;
  assign sec_h_digit_o  = sec_h_q;
  assign sec_l_digit_o  = sec_l_q;
  assign sec_tick_o     = tick_q;
  assign time_valid_o   = valid_q;
  assign load_err_o     = err_q;

endmodule
